// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving mux_4_to_1.sel. The selected data_out is captured
// into a one-entry output register with a valid/ready handshake.

module mux4_rr_lane #(
   parameter int NUM_LANES = 4,
   parameter int PW        = 2,
   parameter int IDX       = 0
) (
   input  logic [NUM_LANES-1:0] in_valid,
   input  logic [PW-1:0]        ptr,
   output logic                 win
);
   logic [PW-1:0] dist_self;

   // Distance from ptr in rotated priority order; smaller distance wins.
   assign dist_self = PW'(IDX) - ptr;

   always_comb begin
      win = in_valid[IDX];
      for (int j = 0; j < NUM_LANES; j++) begin
         if (j != IDX && in_valid[j] && ((PW'(j) - ptr) < dist_self))
            win = 1'b0;
      end
   end
endmodule

module mux4_rr_arbiter #(
   parameter int WIDTH  = 32,
   parameter int width2 = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        in_valid,
   output logic [3:0]        in_ready,
   output logic [width2-1:0] sel,
   input  logic [WIDTH-1:0]  mux_data,
   output logic              out_valid,
   output logic [WIDTH-1:0]  out_data,
   input  logic              out_ready
);
   localparam int NUM_LANES = 4;

   logic [width2-1:0]    ptr;
   logic [width2-1:0]    last_sel;
   logic [NUM_LANES-1:0] win;
   logic [width2-1:0]    winner;
   logic                 can_accept;
   logic                 accept;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      mux4_rr_lane #(
         .NUM_LANES (NUM_LANES),
         .PW        (width2),
         .IDX       (i)
      ) u_lane (
         .in_valid (in_valid),
         .ptr      (ptr),
         .win      (win[i])
      );
   end

   always_comb begin
      winner = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (win[i]) winner = width2'(i);
      end
   end

   // Requests are ignored while reset is held so nothing is granted and lost.
   assign can_accept = !out_valid || out_ready;
   assign accept     = !rst && can_accept && (|in_valid);
   assign sel        = accept ? winner : last_sel;
   assign in_ready   = accept ? win : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         last_sel  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (accept) begin
         out_data  <= mux_data;
         out_valid <= 1'b1;
         last_sel  <= winner;
         ptr       <= winner + width2'(1);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios followed by random
// requests, checked against a queue-based round-robin reference model.

module tb_mux4_rr_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [1:0]  sel;
   logic [31:0] mux_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic        out_ready;

   logic [31:0] data_r [4];

   always #5 clk = ~clk;

   // Behavioural stand-in for mux_4_to_1.
   assign mux_data = data_r[sel];

   mux4_rr_arbiter #(.WIDTH(32), .width2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mux_data  (mux_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready)
   );

   int          n_chk  = 0;
   int          n_fail = 0;
   int          m_ptr  = 0;
   int          m_last = 0;
   bit          m_ov   = 0;
   logic [31:0] q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented output word must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            if (q.size() == 0) check("out_unexpected", out_valid, 1'b0);
            else begin
               check("out_data", out_data, q[0]);
               if (out_ready) void'(q.pop_front());
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data",  out_data,  32'd0);
      check("rst_in_ready",  in_ready,  4'd0);
      check("rst_sel",       sel,       2'd0);
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 4'b0000;
      q.delete(); m_ptr = 0; m_last = 0; m_ov = 0;
   endtask

   // One cycle: drive inputs, predict from the round-robin rule, check, advance model.
   task automatic step(input logic [3:0] v, input logic ordy, output logic acc, output int win);
      logic [3:0] exp_rdy;
      int         exp_sel;
      in_valid = v; out_ready = ordy;
      win = -1;
      for (int k = 0; k < 4; k++)
         if (win < 0 && v[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      acc     = (!m_ov || ordy) && (v != 4'd0);
      exp_rdy = acc ? 4'(1 << win) : 4'd0;
      exp_sel = acc ? win : m_last;
      @(negedge clk);
      check("in_ready",  in_ready,  exp_rdy);
      check("sel",       sel,       exp_sel);
      check("out_valid", out_valid, m_ov);
      if (acc) q.push_back(data_r[win]);
      @(posedge clk);
      if (acc) begin
         m_ov = 1; m_ptr = (win + 1) % 4; m_last = win;
      end else if (ordy) m_ov = 0;
      #1;
   endtask

   logic       acc;
   int         win;
   logic [3:0] pend;
   int         wait_acc [4];

   initial begin
      rst = 1'b1; in_valid = 4'd0; out_ready = 1'b0;
      data_r[0] = 32'd7; data_r[1] = 32'd4; data_r[2] = 32'd3; data_r[3] = 32'd8;
      #1;
      do_reset();

      // Single requester, then wrap past channel 3 and skip it.
      step(4'b0100, 1'b1, acc, win);
      check("single_sel", win, 2);
      step(4'b0000, 1'b1, acc, win);
      step(4'b0011, 1'b1, acc, win);
      check("wrap_grant0", win, 0);
      step(4'b0010, 1'b1, acc, win);
      step(4'b0000, 1'b1, acc, win);

      // Round robin from reset: 0,1,2,3,0,1,2,3.
      do_reset();
      for (int i = 0; i < 8; i++) step(4'b1111, 1'b1, acc, win);
      step(4'b0000, 1'b1, acc, win);

      // Backpressure after one accept, then resume.
      step(4'b1111, 1'b1, acc, win);
      for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, acc, win);
      step(4'b1111, 1'b1, acc, win);
      step(4'b0000, 1'b1, acc, win);

      // Reset while a word is held.
      do_reset();
      step(4'b0010, 1'b0, acc, win);
      do_reset();
      step(4'b1111, 1'b1, acc, win);
      check("post_rst_grant", win, 0);
      step(4'b0000, 1'b1, acc, win);

      // Random: sources hold requests until granted, fresh data per grant.
      pend = 4'd0;
      for (int i = 0; i < 4; i++) begin
         wait_acc[i] = 0;
         data_r[i] = {6'(i), 26'($urandom)};
      end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++)
            if (!pend[i] && ($urandom_range(0, 2) != 0)) pend[i] = 1'b1;
         step(pend, ($urandom_range(0, 3) != 0), acc, win);
         if (acc) begin
            for (int i = 0; i < 4; i++)
               if (pend[i] && i != win) wait_acc[i]++;
            check("fairness", (wait_acc[win] <= 3), 1'b1);
            wait_acc[win] = 0;
            pend[win] = 1'b0;
            data_r[win] = {6'(win), 26'($urandom)};
         end
      end
      step(4'b0000, 1'b1, acc, win);
      step(4'b0000, 1'b1, acc, win);
      check("drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter and output register that sits directly upstream of `mux_4_to_1` and drives its `sel` input. Each cycle it picks one of four valid/ready requesters and drives `sel` to that requester's index. It captures the mux's `data_out`, returned on `mux_data`, into a one-entry output register with a valid/ready handshake. This lets four 32-bit sources share one downstream consumer fairly, at up to one transfer per cycle.

## Interface
Reset is synchronous and active-high. The block has one clock.

Parameters:
- `WIDTH`, 32: data width; must match the `WIDTH` of `mux_4_to_1`.
- `width2`, 2: select width; fixed at 2 for four channels.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 4: bit i is set when source i holds data on `data<i>` of the mux.
- `in_ready`, output, 4: one-hot or zero; bit i high means source i is transferred this cycle.
- `sel`, output, `width2`: drives `mux_4_to_1.sel`.
- `mux_data`, input, `WIDTH`: the `mux_4_to_1.data_out` feedback.
- `out_valid`, output, 1: `out_data` holds an unconsumed word.
- `out_data`, output, `WIDTH`: registered word.
- `out_ready`, input, 1: downstream accepts `out_data` this cycle.

## Operation
- State registers:
  - `ptr`, 2 bits, the highest-priority channel;
  - `last_sel`, 2 bits;
  - `out_valid`;
  - `out_data`.
- `can_accept = !out_valid || out_ready`.
- `winner`: first i with `in_valid[i]=1`, searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, modulo 4 (wraps 3→0).
- `accept = can_accept && |in_valid`.
- Combinational outputs:
  - `sel = accept ? winner : last_sel`;
  - `in_ready[winner] = accept`, all other bits 0.
- On a clock edge with `accept`:
  - `out_data <= mux_data`;
  - `out_valid <= 1`;
  - `last_sel <= winner`;
  - `ptr <= winner + 1` (mod 4).
- On a clock edge with no `accept` and `out_ready`: `out_valid <= 0`; `out_data` holds.
- Backpressure (`out_valid && !out_ready`):
  - `in_ready` is 0;
  - `ptr`, `last_sel` and `out_data` are frozen;
  - `sel` shows `last_sel`.
- No request: `in_ready` is 0, `sel` shows `last_sel`, `ptr` holds.
- Arbitration is fresh every cycle; there is no lock. A source dropping `in_valid` before its grant is simply skipped.
- Sources hold `in_valid` and their data until granted. The arbiter does not check this.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `in_ready=0`, `sel=0`;
  - internally `ptr=0`, `last_sel=0`.
- Reset mid-operation: the next edge clears everything to the reset values, and any word held in `out_data` is dropped. Inputs are ignored while `rst=1`.
- Latency: a source granted in cycle N appears on `out_data` with `out_valid=1` in cycle N+1.
- Throughput: one word per cycle while `out_ready=1`. Accept and drain happen in the same cycle when `out_valid && out_ready` and a request is pending.
- Fairness: with all four requesting continuously and `out_ready=1`, grants follow 0,1,2,3,0,… Any continuously requesting source is granted within 4 accepts.
- The `sel → mux_data` path is combinational through `mux_4_to_1` and is captured in the same cycle.
- `out_data` changes only on an accept edge.

## Test plan
- **Reset:** hold `rst=1` for 2 cycles with all inputs active -> `out_valid=0`, `in_ready=0`, `sel=0`, `out_data=0`. After release, the first grant goes to channel 0.
- **Single requester:** mux data {7,4,3,8}, `in_valid=4'b0100`, `out_ready=1` -> `sel=2`, `in_ready=4'b0100`. Next cycle `out_data=3`, `out_valid=1`.
- **Round robin:** `in_valid=4'b1111` held for 8 cycles, `out_ready=1` -> `sel` sequence 0,1,2,3,0,1,2,3. `out_data` sequence 7,4,3,8,7,4,3,8, one cycle later.
- **Wrap and skip:** `ptr=3` after granting channel 2, then `in_valid=4'b0011` -> grant 0, then 1. Channel 3 is not granted.
- **Backpressure:** `out_ready=0` after the first accept -> `out_valid` stays 1, `out_data` stays stable, `in_ready=0`, `ptr` frozen. Raising `out_ready` resumes with the next channel in round-robin order, with no loss or duplication.
- **Reset mid-stream:** assert `rst` while `out_valid=1` and `out_data=4` -> next cycle `out_valid=0`, `out_data=0`. The next grant goes to channel 0.
